alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 170 +++++++++++++++++
 tb/tb_alu_mdu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: ALU with an iterative multiply/divide unit behind a valid/ready handshake.
//   clk, reset (async, active-high), flush (sync cancel)
//   in_valid/in_ready, alu_op[4:0], alu_src1, alu_src2 : request side
//   out_valid/out_ready, alu_result                   : result side
// Ops 0-11 and 19-31 complete in one cycle. MUL/MULH/MULHU/DIV/MOD/DIVU/MODU
// run a radix-2 shift-add / restoring-divide loop of WIDTH iterations.
module alu_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT  = 5'd2,  OP_SLTU  = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_NOR = 5'd5,  OP_OR   = 5'd6,  OP_XOR   = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL = 5'd9,  OP_SRA  = 5'd10, OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd12, OP_MULH = 5'd13, OP_MULHU = 5'd14;
  localparam logic [4:0] OP_DIV = 5'd15, OP_MOD = 5'd16, OP_DIVU = 5'd17, OP_MODU = 5'd18;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state, w_state_n;
  logic [4:0]           r_op;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_hi, r_lo, r_b, r_src1, r_result;
  logic                 r_neg, r_s1neg, r_zero;

  logic                 w_accept, w_is_iter, w_sgn, w_last;
  logic [SHAMT_W-1:0]   w_sh;
  logic [WIDTH-1:0]     w_alu, w_abs1, w_abs2, w_final;
  logic [WIDTH:0]       w_msum, w_rsh, w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_mhi_n, w_mlo_n, w_dhi_n, w_dlo_n;
  logic [2*WIDTH-1:0]   w_prod, w_prod_s;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (WIDTH'(0) - x) : x;
  endfunction

  // Handshake
  assign in_ready  = ~flush & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == DONE);
  assign alu_result = r_result;

  assign w_is_iter = (alu_op >= OP_MUL) && (alu_op <= OP_MODU);
  assign w_sgn     = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_MOD);
  assign w_last    = (r_cnt == SHAMT_W'(WIDTH - 1));
  assign w_sh      = alu_src2[SHAMT_W-1:0];
  assign w_abs1    = f_abs(alu_src1);
  assign w_abs2    = f_abs(alu_src2);

  // Single-cycle result, computed straight from the request inputs
  always_comb begin
    w_alu = '0;
    case (alu_op)
      OP_ADD:  w_alu = alu_src1 + alu_src2;
      OP_SUB:  w_alu = alu_src1 - alu_src2;
      OP_SLT:  w_alu = WIDTH'($signed(alu_src1) < $signed(alu_src2));
      OP_SLTU: w_alu = WIDTH'(alu_src1 < alu_src2);
      OP_AND:  w_alu = alu_src1 & alu_src2;
      OP_NOR:  w_alu = ~(alu_src1 | alu_src2);
      OP_OR:   w_alu = alu_src1 | alu_src2;
      OP_XOR:  w_alu = alu_src1 ^ alu_src2;
      OP_SLL:  w_alu = alu_src1 << w_sh;
      OP_SRL:  w_alu = alu_src1 >> w_sh;
      OP_SRA:  w_alu = WIDTH'($signed(alu_src1) >>> w_sh);
      OP_LUI:  w_alu = alu_src2;
      default: w_alu = '0;
    endcase
  end

  // One multiply step: {hi,lo} shifts right, multiplier bits leave from lo[0]
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mhi_n = w_msum[WIDTH:1];
  assign w_mlo_n = {w_msum[0], r_lo[WIDTH-1:1]};

  // One restoring-divide step: hi is the partial remainder, lo the dividend/quotient
  assign w_rsh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_rsh - {1'b0, r_b};
  assign w_qbit  = ~w_diff[WIDTH];
  assign w_dhi_n = w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
  assign w_dlo_n = {r_lo[WIDTH-2:0], w_qbit};

  // Sign correction on magnitudes after the last step
  assign w_prod   = {w_mhi_n, w_mlo_n};
  assign w_prod_s = r_neg ? ((2*WIDTH)'(0) - w_prod) : w_prod;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:             w_final = w_prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHU:  w_final = w_prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:    w_final = r_zero ? '1 :
                                    (r_neg ? (WIDTH'(0) - w_dlo_n) : w_dlo_n);
      OP_MOD, OP_MODU:    w_final = r_zero ? r_src1 :
                                    (r_s1neg ? (WIDTH'(0) - w_dhi_n) : w_dhi_n);
      default:            w_final = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Next state
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_n = w_is_iter ? BUSY : DONE;
      BUSY: if (w_last)   w_state_n = DONE;
      DONE: if (out_ready) begin
        if (w_accept) w_state_n = w_is_iter ? BUSY : DONE;
        else          w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (flush) w_state_n = IDLE;
  end

  // Datapath: latch on accept, iterate in BUSY, write result on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_src1   <= '0;
      r_neg    <= 1'b0;
      r_s1neg  <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= alu_op;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= w_sgn ? w_abs1 : alu_src1;
      r_b     <= w_sgn ? w_abs2 : alu_src2;
      r_src1  <= alu_src1;
      r_neg   <= w_sgn & (alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]);
      r_s1neg <= w_sgn & alu_src1[WIDTH-1];
      r_zero  <= (alu_src2 == '0);
      if (!w_is_iter) r_result <= w_alu;
    end else if ((r_state == BUSY) && !flush) begin
      r_cnt <= r_cnt + SHAMT_W'(1);
      if (r_op >= OP_DIV) begin
        r_hi <= w_dhi_n;
        r_lo <= w_dlo_n;
      end else begin
        r_hi <= w_mhi_n;
        r_lo <= w_mlo_n;
      end
      if (w_last) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table plus hand-written handshake, flush and reset sequences.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_op = 5'd0;
  logic [31:0] alu_src1 = 32'd0;
  logic [31:0] alu_src2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready high, scramble inputs after acceptance, check result and latency
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int exp_lat;
    exp_lat = (op >= 5'd12 && op <= 5'd18) ? 33 : 1;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; alu_src1 = a; alu_src2 = b; out_ready = 1'b1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_op = 5'd3; alu_src1 = ~a; alu_src2 = ~b;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 100) break;
    end
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, alu_result, exp);
  endtask

  initial begin
    bit seen;

    vecs.push_back('{5'd0,  32'd5,        32'd7,        32'd12});
    vecs.push_back('{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE});
    vecs.push_back('{5'd2,  32'hFFFFFFFF, 32'd1,        32'd1});
    vecs.push_back('{5'd3,  32'hFFFFFFFF, 32'd1,        32'd0});
    vecs.push_back('{5'd4,  32'hF0F000FF, 32'h0FF0F0F0, 32'h00F000F0});
    vecs.push_back('{5'd5,  32'hF0F000FF, 32'h0FF0F0F0, 32'h000F0F00});
    vecs.push_back('{5'd6,  32'hF0F000FF, 32'h0FF0F0F0, 32'hFFF0F0FF});
    vecs.push_back('{5'd7,  32'hF0F000FF, 32'h0FF0F0F0, 32'hFF00F00F});
    vecs.push_back('{5'd8,  32'd1,        32'h24,       32'h10});
    vecs.push_back('{5'd9,  32'h80000000, 32'h21,       32'h40000000});
    vecs.push_back('{5'd10, 32'h80000000, 32'h21,       32'hC0000000});
    vecs.push_back('{5'd11, 32'd7,        32'h12345000, 32'h12345000});
    vecs.push_back('{5'd20, 32'd9,        32'd9,        32'd0});
    vecs.push_back('{5'd12, 32'h12345678, 32'h10,       32'h23456780});
    vecs.push_back('{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1});
    vecs.push_back('{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0});
    vecs.push_back('{5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{5'd13, 32'h80000000, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0});
    vecs.push_back('{5'd15, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vecs.push_back('{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{5'd16, 32'd7,        32'hFFFFFFFE, 32'd1});
    vecs.push_back('{5'd17, 32'd100,      32'd7,        32'd14});
    vecs.push_back('{5'd18, 32'd100,      32'd7,        32'd2});
    vecs.push_back('{5'd17, 32'd7,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{5'd18, 32'd7,        32'd0,        32'd7});
    vecs.push_back('{5'd15, 32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{5'd16, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB});

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) do_op($sformatf("vec%0d_op%0d", i, vecs[i].op),
                            vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Back-to-back ADDs with 3 cycles of backpressure
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd0; alu_src1 = 32'd1; alu_src2 = 32'd2; out_ready = 1'b1;
    @(posedge clk);
    #1;
    alu_src1 = 32'd3; alu_src2 = 32'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_result%0d", k), alu_result, 32'd3);
      chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_result", alu_result, 32'd7);
    @(negedge clk);
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Flush at cycle 10 of a DIV
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd15; alu_src1 = 32'd100; alu_src2 = 32'd3; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = 5'd0;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Reset pulse mid-MUL; result register holds 7 from the ADDs above
    chk("pre_rst_result", alu_result, 32'd7);
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd12; alu_src1 = 32'd9; alu_src2 = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", alu_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Recovery after reset
    do_op("post_rst_add", 5'd0, 32'd40, 32'd2, 32'd42);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
